// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared half-adder pair forms a full adder, one bit per clock.
// Optional subtraction (sub port, ~b and carry-in 1) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sa_next;
  logic [WIDTH-1:0] sb_reg, sb_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             cy_reg, cy_next;
  logic             co_reg, co_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             sub_sel;
  logic             s1, c1, s, c2, cy_new;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH-1:0] acc_shift;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // The two half-adders acting as one full adder on the current LSBs.
  assign s1        = sa_reg[0] ^ sb_reg[0];
  assign c1        = sa_reg[0] & sb_reg[0];
  assign s         = s1 ^ cy_reg;
  assign c2        = s1 & cy_reg;
  assign cy_new    = c1 | c2;
  assign acc_ext   = {s, acc_reg};
  assign acc_shift = acc_ext[WIDTH:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      cy_reg    <= 1'b0;
      co_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sa_reg    <= sa_next;
      sb_reg    <= sb_next;
      acc_reg   <= acc_next;
      sum_reg   <= sum_next;
      cnt_reg   <= cnt_next;
      cy_reg    <= cy_next;
      co_reg    <= co_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sa_next    = sa_reg;
    sb_next    = sb_reg;
    acc_next   = acc_reg;
    sum_next   = sum_reg;
    cnt_next   = cnt_reg;
    cy_next    = cy_reg;
    co_next    = co_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          sa_next    = a;
          sb_next    = sub_sel ? ~b : b;
          cnt_next   = '0;
          cy_next    = sub_sel;
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        cy_next  = cy_new;
        acc_next = acc_shift;
        sa_next  = sa_reg >> 1;
        sb_next  = sb_reg >> 1;
        cnt_next = cnt_reg + CW'(1);
        // Counter holds WIDTH-1 while the MSB is being added: last bit.
        if (cnt_reg == CW'(WIDTH - 1)) begin
          sum_next   = acc_shift;
          co_next    = cy_new;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign sum       = sum_reg;
  assign carry_out = co_reg;

endmodule
